// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: datapath widths, reset PC, NOP encoding and
// the PC+instruction pair that moves through the fetch path.
package if_stage_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned INST_LEN = 32;

    localparam logic [XLEN-1:0]     RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [INST_LEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry PC+instruction holding buffer between the memory response and the
// ID-facing output register. Flush wins over write; write wins over read.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_entry,
    input  logic         rd_en,
    output logic         full,
    output fetch_entry_t rd_entry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full           <= 1'b0;
            rd_entry.pc    <= '0;
            rd_entry.instr <= NOP_INSTR;
        end else if (flush) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full     <= 1'b1;
            rd_entry <= wr_entry;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding-request memory fetcher with a
// held output register toward ID, a one-entry skid buffer and redirect/kill.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stalln_pc,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INST_LEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0]     pc_o,
    output logic [INST_LEN-1:0] instr_o,
    output logic                valid_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            req_en;
    logic            req_fire;
    logic            resp_live;

    logic            skid_full;
    logic            skid_wr;
    logic            skid_rd;
    fetch_entry_t    skid_entry;
    fetch_entry_t    resp_entry;

    logic            out_load;
    logic            valid_d;
    fetch_entry_t    out_d;

    assign resp_entry  = {req_pc_q, imem_rdata_i};
    assign imem_req_o  = req_en;
    assign imem_addr_o = align_pc(fetch_pc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A killed request still owes one response, so no new request may go out
    // until that response has been swallowed (kill keeps req low).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        req_en     = 1'b0;
        req_fire   = 1'b0;
        resp_live  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                req_en = !skid_full && !kill_q;
                if (req_en && imem_gnt_i) begin
                    req_fire   = 1'b1;
                    state_d    = S_WAIT;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    req_pc_d   = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d   = S_REQ;
                    resp_live = !kill_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill_q && imem_rvalid_i && state_q != S_IDLE) begin
            kill_d = 1'b0;
        end

        if (redirect_i) begin
            state_d    = S_REQ;
            fetch_pc_d = align_pc(redirect_pc_i);
            resp_live  = 1'b0;
            kill_d     = req_fire
                      || (state_q == S_WAIT && !imem_rvalid_i)
                      || (kill_q && !imem_rvalid_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
        end
    end

    // Output register advances when empty or being consumed; skid content is
    // older than any same-cycle response, so it is presented first.
    always_comb begin
        out_load = 1'b0;
        out_d    = resp_entry;
        valid_d  = valid_o;
        skid_wr  = 1'b0;
        skid_rd  = 1'b0;

        if (!valid_o || stalln_pc) begin
            if (skid_full) begin
                out_load = 1'b1;
                out_d    = skid_entry;
                valid_d  = 1'b1;
                skid_rd  = 1'b1;
                skid_wr  = resp_live;
            end else if (resp_live) begin
                out_load = 1'b1;
                valid_d  = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            skid_wr = resp_live;
        end

        if (redirect_i) begin
            out_load = 1'b0;
            valid_d  = 1'b0;
            skid_wr  = 1'b0;
            skid_rd  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            pc_o    <= '0;
            instr_o <= NOP_INSTR;
        end else begin
            valid_o <= valid_d;
            if (out_load) begin
                pc_o    <= out_d.pc;
                instr_o <= out_d.instr;
            end
        end
    end

    if_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_i),
        .wr_en    (skid_wr),
        .wr_entry (resp_entry),
        .rd_en    (skid_rd),
        .full     (skid_full),
        .rd_entry (skid_entry)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: reset, first fetch, stall/skid,
// redirects (REQ, WAIT, with rvalid, under stall), PC wrap and reset mid-WAIT.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stalln_pc;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [63:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stalln_pc     (stalln_pc),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; stalln_pc = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        #2 rst_n = 1'b0;
        tick(); tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (pc_o !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
        rst_n = 1'b1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req_o); end
        tick();
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL first_addr: got %h expected 80000000", imem_addr_o); end
    endtask

    task automatic test_first_fetch();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL wait_req: got %b expected 0", imem_req_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b expected 0", valid_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0093;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b expected 1", valid_o); end
        checks++; if (pc_o !== 64'h8000_0000) begin errors++; $display("FAIL ff_pc: got %h expected 80000000", pc_o); end
        checks++; if (instr_o !== 32'h0000_0093) begin errors++; $display("FAIL ff_instr: got %h expected 00000093", instr_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0004) begin errors++; $display("FAIL ff_next_req: got %b/%h expected 1/80000004", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_stall();
        stalln_pc = 1'b0; imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_000A;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000) begin errors++; $display("FAIL stall_hold1: got %b/%h expected 1/80000000", valid_o, pc_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_noreq1: got %b expected 0", imem_req_o); end
        tick();
        checks++; if (pc_o !== 64'h8000_0000 || instr_o !== 32'h0000_0093) begin errors++; $display("FAIL stall_hold2: got %h/%h expected 80000000/00000093", pc_o, instr_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_noreq2: got %b expected 0", imem_req_o); end
        stalln_pc = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0004) begin errors++; $display("FAIL skid_pc: got %b/%h expected 1/80000004", valid_o, pc_o); end
        checks++; if (instr_o !== 32'h0000_000A) begin errors++; $display("FAIL skid_instr: got %h expected 0000000a", instr_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0008) begin errors++; $display("FAIL drain_req: got %b/%h expected 1/80000008", imem_req_o, imem_addr_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL consumed_valid: got %b expected 0", valid_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_000B;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0008 || instr_o !== 32'h0000_000B) begin errors++; $display("FAIL third_out: got %b/%h/%h expected 1/80000008/0000000b", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_wait();
        redirect_i = 1'b1; redirect_pc_i = 64'h8000_0004;
        tick();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0004) begin errors++; $display("FAIL rdr_req_addr: got %b/%h expected 1/80000004", imem_req_o, imem_addr_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rdr_req_valid: got %b expected 0", valid_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0102;
        tick();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL kill_noreq: got %b expected 0", imem_req_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_DEAD;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL kill_drop: got %b expected 0", valid_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0100) begin errors++; $display("FAIL kill_next_req: got %b/%h expected 1/80000100", imem_req_o, imem_addr_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0113;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rdr_wait_valid: got %b expected 0", valid_o); end
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0100 || instr_o !== 32'h0000_0113) begin errors++; $display("FAIL rdr_out: got %b/%h/%h expected 1/80000100/00000113", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_rvalid();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0213;
        redirect_i = 1'b1; redirect_pc_i = 64'h8000_0200;
        tick();
        imem_rvalid_i = 1'b0; redirect_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rv_rdr_valid: got %b expected 0", valid_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0200) begin errors++; $display("FAIL rv_rdr_req: got %b/%h expected 1/80000200", imem_req_o, imem_addr_o); end
        tick();
        checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b1) begin errors++; $display("FAIL rv_rdr_nokill: got %b/%b expected 0/1", valid_o, imem_req_o); end
    endtask

    task automatic test_redirect_stall();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0313;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0200) begin errors++; $display("FAIL rs_pre: got %b/%h expected 1/80000200", valid_o, pc_o); end
        stalln_pc = 1'b0; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0300;
        tick();
        redirect_i = 1'b0; stalln_pc = 1'b1;
        checks++; if (valid_o !== 1'b0 || imem_addr_o !== 64'h8000_0300) begin errors++; $display("FAIL rs_override: got %b/%h expected 0/80000300", valid_o, imem_addr_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        checks++; if (imem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h expected fffffffffffffffc", imem_addr_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0413;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %b/%h expected 1/fffffffffffffffc", valid_o, pc_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin errors++; $display("FAIL wrap_addr: got %b/%h expected 1/0", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_reset_mid_wait();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || pc_o !== 64'h0 || instr_o !== 32'h0000_0013) begin errors++; $display("FAIL async_rst: got %b/%h/%h expected 0/0/00000013", valid_o, pc_o, instr_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL async_rst_req: got %b expected 0", imem_req_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0BAD;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stale_rvalid: got %b expected 0", valid_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL restart_req: got %b/%h expected 1/80000000", imem_req_o, imem_addr_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0513;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000 || instr_o !== 32'h0000_0513) begin errors++; $display("FAIL restart_out: got %b/%h/%h expected 1/80000000/00000513", valid_o, pc_o, instr_o); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
